// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the icache read port (I) and the dcache
// read/write port (D) onto one single-port memory with a registered
// request/acknowledge handshake. One transaction owns the memory at a time;
// its address and write data are latched at grant and held until it ends.
//
// Transaction shape (one IDLE cycle between transactions):
//   IDLE (req seen) -> ACCESS x1 (write) or x(MEM_LAT+1) (read) -> RESP (ack)
// The memory address is registered, so it first reaches the memory in the
// first ACCESS cycle. Read data is therefore valid MEM_LAT cycles after that.
//
// Optional build macro: MEM_ARB_DPRIO_EN
//   undefined (default) : round-robin on contention, port I wins the first one
//   defined             : fixed priority, port D always wins contention
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int MEM_LAT = 1,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  // icache port (read only)
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rd_data,
  // dcache port (read/write)
  input  logic              d_req,
  input  logic              d_wr_en,
  input  logic [AW-1:0]     d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rd_data,
  // memory port
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  // status
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Counter starts at MEM_LAT: one cycle for the registered address to reach
  // the memory plus MEM_LAT cycles of memory read latency.
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  state_t              state_q,   state_d;
  logic [2:0]          cnt_q,     cnt_d;
  logic                owner_q,   owner_d;
  logic                wr_q,      wr_d;
  logic [AW-1:0]       addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic                wr_en_q,   wr_en_d;
  logic                i_ack_q,   i_ack_d;
  logic                d_ack_q,   d_ack_d;
  logic [DATA_W-1:0]   i_rd_q,    i_rd_d;
  logic [DATA_W-1:0]   d_rd_q,    d_rd_d;
  logic                busy_q,    busy_d;
`ifndef MEM_ARB_DPRIO_EN
  logic                last_q,    last_d;
`endif
  logic                grant_port;

`ifdef MEM_ARB_DPRIO_EN
  // Fixed priority: D wins whenever it is requesting.
  function automatic logic pick_port(input logic req_i, input logic req_d);
    if (req_d) return PORT_D;
    if (req_i) return PORT_I;
    return PORT_I;
  endfunction
`else
  // Round-robin: on contention the port that was not granted last wins.
  function automatic logic pick_port(input logic req_i, input logic req_d,
                                     input logic last);
    if (req_i && req_d) return ~last;
    if (req_d)          return PORT_D;
    return PORT_I;
  endfunction
`endif

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    i_rd_d  = i_rd_q;
    d_rd_d  = d_rd_q;
    busy_d  = busy_q;
`ifdef MEM_ARB_DPRIO_EN
    grant_port = pick_port(i_req, d_req);
`else
    last_d     = last_q;
    grant_port = pick_port(i_req, d_req, last_q);
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // Latch the winner's request so requester inputs may move freely.
          owner_d = grant_port;
          addr_d  = (grant_port == PORT_D) ? d_addr : i_addr;
          if (grant_port == PORT_D) wdata_d = d_wr_data;
          // Port I can never write.
          wr_d    = (grant_port == PORT_D) && d_wr_en;
          wr_en_d = (grant_port == PORT_D) && d_wr_en;
          cnt_d   = LAT_LOAD;
          busy_d  = 1'b1;
          state_d = ST_ACCESS;
`ifndef MEM_ARB_DPRIO_EN
          last_d  = grant_port;
`endif
        end
      end

      ST_ACCESS: begin
        if (wr_q) begin
          // The strobe fired on entry to ACCESS; the write is complete.
          d_ack_d = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == 3'd0) begin
          if (owner_q == PORT_D) begin
            d_rd_d  = mem_rd_data;
            d_ack_d = 1'b1;
          end else begin
            i_rd_d  = mem_rd_data;
            i_ack_d = 1'b1;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register every piece of state and every output; active-low sync reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      owner_q <= PORT_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_rd_q  <= '0;
      d_rd_q  <= '0;
      busy_q  <= 1'b0;
`ifndef MEM_ARB_DPRIO_EN
      last_q  <= PORT_D;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      i_rd_q  <= i_rd_d;
      d_rd_q  <= d_rd_d;
      busy_q  <= busy_d;
`ifndef MEM_ARB_DPRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign mem_wr_en   = wr_en_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign i_rd_data   = i_rd_q;
  assign d_rd_data   = d_rd_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 1024x32 memory with TB_LAT read latency,
// a transaction-level reference model checked every cycle, directed cases
// with literal expectations, and a randomized two-requester phase.
module tb_mem_port_arbiter;
  parameter int TB_LAT = 1;
  localparam int AW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr_en;
  logic [31:0] i_addr, d_addr, d_wr_data;
  logic        i_ack, d_ack, mem_wr_en, busy, owner;
  logic [31:0] i_rd_data, d_rd_data, mem_addr, mem_wr_data, mem_rd_data;

  mem_port_arbiter #(.AW(AW), .MEM_LAT(TB_LAT), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rd_data(i_rd_data),
    .d_req(d_req), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_ack(d_ack), .d_rd_data(d_rd_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 48) return 32'h12345678;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Memory: registered read pipeline of TB_LAT stages, write on strobe.
  logic [31:0] mem [1024];
  logic [31:0] rpipe [TB_LAT];
  bit mem_ready = 1'b0;
  assign mem_rd_data = rpipe[TB_LAT-1];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_wr_en) begin
      mem[mem_addr[9:0]] <= mem_wr_data;
    end
    rpipe[0] <= mem[mem_addr[9:0]];
    for (int k = 1; k < TB_LAT; k++) rpipe[k] <= rpipe[k-1];
  end

  // Reference model: one transaction record, timeline from the grant cycle.
  logic [31:0] ref_mem [1024];
  bit          armed = 1'b0;
  bit          m_act = 1'b0;
  bit          m_win, m_wr;
  bit          m_last = 1'b1;
  int          m_start, m_end;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] exp_i_rd = 32'h0;
  logic [31:0] exp_d_rd = 32'h0;
  bit          ack_seq[$];

  always @(negedge clk) begin
    int t;
    bit in_txn;
    t = cyc_n;
    if (armed) begin
      in_txn = m_act && (t > m_start) && (t <= m_end);
      if (in_txn && t == m_end && !m_wr) begin
        if (m_win) exp_d_rd = m_rdata; else exp_i_rd = m_rdata;
      end
      check("busy", 32'(busy), 32'(in_txn));
      if (in_txn) check("owner", 32'(owner), 32'(m_win));
      check("i_ack", 32'(i_ack), 32'(in_txn && t == m_end && !m_win));
      check("d_ack", 32'(d_ack), 32'(in_txn && t == m_end && m_win));
      check("mem_wr_en", 32'(mem_wr_en), 32'(in_txn && m_wr && t == m_start + 1));
      if (in_txn && t < m_end) check("mem_addr", mem_addr, m_addr);
      if (in_txn && m_wr && t == m_start + 1) check("mem_wr_data", mem_wr_data, m_wdata);
      check("i_rd_data", i_rd_data, exp_i_rd);
      check("d_rd_data", d_rd_data, exp_d_rd);
      if (i_ack === 1'b1) ack_seq.push_back(1'b0);
      if (d_ack === 1'b1) ack_seq.push_back(1'b1);

      if (!rst) begin
        m_act = 1'b0; m_last = 1'b1; exp_i_rd = 32'h0; exp_d_rd = 32'h0;
      end else if (!m_act || t > m_end) begin
        m_act = 1'b0;
        if (i_req || d_req) begin
          if (i_req && d_req) begin
`ifdef MEM_ARB_DPRIO_EN
            m_win = 1'b1;
`else
            m_win = !m_last;
`endif
          end else begin
            m_win = d_req;
          end
          m_last  = m_win;
          m_wr    = m_win && d_wr_en;
          m_addr  = m_win ? d_addr : i_addr;
          m_wdata = d_wr_data;
          m_rdata = ref_mem[m_addr[9:0]];
          if (m_wr) ref_mem[m_addr[9:0]] = m_wdata;
          m_start = t;
          m_end   = t + (m_wr ? 2 : TB_LAT + 2);
          m_act   = 1'b1;
        end
      end
    end
    if (!rst) armed = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run one transaction already requested this cycle; report latency to ack,
  // write strobes seen, and whether mem_addr stayed at eaddr while busy.
  task automatic xfer(input bit port, input logic [31:0] eaddr, input int chg_at,
                      input logic [31:0] chg_addr, output int lat, output int wrs,
                      output logic [31:0] wra, output bit hold);
    bit ackv;
    lat = -1; wrs = 0; wra = 32'h0; hold = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ackv = port ? d_ack : i_ack;
      if (mem_wr_en === 1'b1) begin wrs++; wra = mem_addr; end
      if (busy === 1'b1 && !ackv && mem_addr !== eaddr) hold = 1'b0;
      if (k == chg_at) begin
        if (port) d_addr = chg_addr; else i_addr = chg_addr;
      end
      if (ackv === 1'b1) begin lat = k; break; end
    end
    @(posedge clk); #1;
    if (port) d_req = 1'b0; else i_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wrs, n_ia;
    logic [31:0] wra;
    bit hold, ia, da;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr_en = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wr_data = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_i_ack", 32'(i_ack), 32'h0);
    check("rst_d_ack", 32'(d_ack), 32'h0);
    check("rst_wr_en", 32'(mem_wr_en), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_i_rd", i_rd_data, 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1);

    // Single I read of 0x10
    i_addr = 32'h10; i_req = 1'b1;
    xfer(1'b0, 32'h10, -1, 32'h0, lat, wrs, wra, hold);
    check("i_rd_lat", 32'(lat), 32'(TB_LAT + 2));
    check("i_rd_data_lit", i_rd_data, 32'hDEADBEEF);
    check("i_rd_addr_hold", 32'(hold), 32'h1);
    check("i_rd_no_wr", 32'(wrs), 32'h0);

    // D write 0xCAFEF00D to 0x20
    d_addr = 32'h20; d_wr_en = 1'b1; d_wr_data = 32'hCAFEF00D; d_req = 1'b1;
    xfer(1'b1, 32'h20, -1, 32'h0, lat, wrs, wra, hold);
    check("d_wr_lat", 32'(lat), 32'h2);
    check("d_wr_strobes", 32'(wrs), 32'h1);
    check("d_wr_addr", wra, 32'h20);

    // D read 0x20, address input moved to 0x30 one cycle after grant
    d_wr_en = 1'b0; d_wr_data = 32'h0; d_req = 1'b1;
    xfer(1'b1, 32'h20, 1, 32'h30, lat, wrs, wra, hold);
    check("d_rd_lat", 32'(lat), 32'(TB_LAT + 2));
    check("d_rd_data_lit", d_rd_data, 32'hCAFEF00D);
    check("d_rd_addr_hold", 32'(hold), 32'h1);

    // Reset during ACCESS of an I read
    i_addr = 32'h20; i_req = 1'b1;
    cyc(1);
    rst = 1'b0; i_req = 1'b0;
    cyc(1);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_i_ack", 32'(i_ack), 32'h0);
    check("mid_rst_i_rd", i_rd_data, 32'h0);
    check("mid_rst_d_rd", d_rd_data, 32'h0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    n_ia = 0;
    repeat (8) begin
      @(negedge clk);
      if (i_ack === 1'b1) n_ia++;
    end
    check("mid_rst_no_ack", 32'(n_ia), 32'h0);

    // Contention from reset: both requests held continuously
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    ack_seq.delete();
    i_addr = 32'h10; d_addr = 32'h20; d_wr_en = 1'b0; i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (ack_seq.size() >= 4) break;
    end
    #1;
    i_req = 1'b0; d_req = 1'b0;
    check("contend_count", 32'(ack_seq.size() >= 4), 32'h1);
    if (ack_seq.size() >= 4) begin
`ifdef MEM_ARB_DPRIO_EN
      check("contend_g0", 32'(ack_seq[0]), 32'h1);
      check("contend_g1", 32'(ack_seq[1]), 32'h1);
      check("contend_g2", 32'(ack_seq[2]), 32'h1);
      check("contend_g3", 32'(ack_seq[3]), 32'h1);
`else
      check("contend_g0", 32'(ack_seq[0]), 32'h0);
      check("contend_g1", 32'(ack_seq[1]), 32'h1);
      check("contend_g2", 32'(ack_seq[2]), 32'h0);
      check("contend_g3", 32'(ack_seq[3]), 32'h1);
`endif
    end
    cyc(2);

    // Randomized two-requester traffic with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ia = i_ack; da = d_ack;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 499) != 0);
      if (i_req && ia) begin
        i_req = ($urandom_range(0, 3) == 0);
        i_addr = $urandom_range(0, 31);
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = $urandom_range(0, 31);
      end else if (i_req && busy && !owner && $urandom_range(0, 3) == 0) begin
        i_addr = $urandom_range(0, 31);
      end
      if (d_req && da) begin
        d_req = ($urandom_range(0, 3) == 0);
        d_addr = $urandom_range(0, 31);
        d_wr_en = $urandom_range(0, 1);
        d_wr_data = $urandom;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_addr = $urandom_range(0, 31);
        d_wr_en = $urandom_range(0, 1);
        d_wr_data = $urandom;
      end else if (d_req && busy && owner && $urandom_range(0, 3) == 0) begin
        d_addr = $urandom_range(0, 31);
        d_wr_data = $urandom;
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    cyc(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
